// File: rtl/brew_if.sv
// Handshake bundle between the vending front-ends and the shared brewing unit.
// The master side drives requests and selects; the slave side is the arbiter.
interface brew_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [4*NUM_REQ-1:0] sel;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   done;
  logic                 busy;
  logic                 cup_drop;
  logic [3:0]           valve;
  logic                 rinse;

  modport master (
    output req, sel,
    input  grant, done, busy, cup_drop, valve, rinse
  );

  modport slave (
    input  req, sel,
    output grant, done, busy, cup_drop, valve, rinse
  );
endinterface

// File: rtl/brew_arbiter.sv
// Round-robin arbiter and dispense sequencer for one shared brewing unit.
// Optional rinse cycle every CLEAN_INTERVAL drinks is enabled by `define BREW_CLEAN_EN.
module brew_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int CUP_CYC  = 16,
  parameter int POUR_CYC = 200,
  parameter int DRIP_CYC = 32
`ifdef BREW_CLEAN_EN
  ,
  parameter int CLEAN_INTERVAL = 8,
  parameter int CLEAN_CYC      = 64
`endif
) (
  input  logic clk,
  input  logic rst,
  brew_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0] NREQ_W  = (PTR_W+1)'(NUM_REQ);
  localparam logic [15:0]    CUP_LD  = 16'(CUP_CYC - 1);
  localparam logic [15:0]    POUR_LD = 16'(POUR_CYC - 1);
  localparam logic [15:0]    DRIP_LD = 16'(DRIP_CYC - 1);
`ifdef BREW_CLEAN_EN
  localparam logic [15:0]    CLEAN_LD = 16'(CLEAN_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_CUP,
    S_POUR,
    S_DRIP,
    S_DONE
`ifdef BREW_CLEAN_EN
    ,
    S_CLEAN
`endif
  } state_t;

  state_t             r_state;
  logic [15:0]        r_timer;
  logic [PTR_W-1:0]   r_cur_id;
  logic [3:0]         r_cur_sel;
  logic [PTR_W-1:0]   r_ptr;
  logic [15:0]        r_drink_cnt;

  state_t             w_state_next;
  logic [15:0]        w_timer_next;
  logic [PTR_W-1:0]   w_cur_id_next;
  logic [3:0]         w_cur_sel_next;
  logic [PTR_W-1:0]   w_ptr_next;
  logic [15:0]        w_drink_cnt_next;

  logic [NUM_REQ-1:0] w_elig;
  logic [3:0]         w_sel [NUM_REQ];
  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W:0]     w_sum;
  logic [PTR_W:0]     w_win_inc;
  logic [NUM_REQ-1:0] w_onehot;

  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_done;
  logic               w_busy;
  logic               w_cup_drop;
  logic [3:0]         w_valve;
  logic               w_rinse;

  // A zero select means "nothing chosen yet", so such a request cannot win.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
    assign w_sel[gi]  = bus.sel[4*gi +: 4];
    assign w_elig[gi] = bus.req[gi] && (w_sel[gi] != 4'd0);
  end

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_sum >= NREQ_W) begin
        w_sum = w_sum - NREQ_W;
      end
      if (!w_found && w_elig[w_sum[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[PTR_W-1:0];
      end
    end
    w_win_inc = {1'b0, w_win} + 1'b1;
    if (w_win_inc == NREQ_W) begin
      w_win_inc = '0;
    end
  end

  assign w_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_cur_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_cur_id    <= '0;
      r_cur_sel   <= '0;
      r_ptr       <= '0;
      r_drink_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_timer     <= w_timer_next;
      r_cur_id    <= w_cur_id_next;
      r_cur_sel   <= w_cur_sel_next;
      r_ptr       <= w_ptr_next;
      r_drink_cnt <= w_drink_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_timer_next     = r_timer;
    w_cur_id_next    = r_cur_id;
    w_cur_sel_next   = r_cur_sel;
    w_ptr_next       = r_ptr;
    w_drink_cnt_next = r_drink_cnt;
    w_grant          = '0;
    w_done           = '0;
    w_busy           = 1'b1;
    w_cup_drop       = 1'b0;
    w_valve          = 4'd0;
    w_rinse          = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_found) begin
          w_cur_id_next  = w_win;
          w_cur_sel_next = w_sel[w_win];
          w_ptr_next     = w_win_inc[PTR_W-1:0];
          w_state_next   = S_GRANT;
        end
      end
      S_GRANT: begin
        w_grant      = w_onehot;
        w_timer_next = CUP_LD;
        w_state_next = S_CUP;
      end
      S_CUP: begin
        w_cup_drop   = 1'b1;
        w_timer_next = r_timer - 16'd1;
        if (r_timer == 16'd0) begin
          w_timer_next = POUR_LD;
          w_state_next = S_POUR;
        end
      end
      S_POUR: begin
        w_valve      = r_cur_sel;
        w_timer_next = r_timer - 16'd1;
        if (r_timer == 16'd0) begin
          w_timer_next = DRIP_LD;
          w_state_next = S_DRIP;
        end
      end
      S_DRIP: begin
        w_timer_next = r_timer - 16'd1;
        if (r_timer == 16'd0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done           = w_onehot;
        w_drink_cnt_next = r_drink_cnt + 16'd1;
        w_state_next     = S_IDLE;
`ifdef BREW_CLEAN_EN
        if (((32'(r_drink_cnt) + 32'd1) % CLEAN_INTERVAL) == 0) begin
          w_timer_next = CLEAN_LD;
          w_state_next = S_CLEAN;
        end
`endif
      end
`ifdef BREW_CLEAN_EN
      S_CLEAN: begin
        w_rinse      = 1'b1;
        w_valve      = 4'b1111;
        w_timer_next = r_timer - 16'd1;
        if (r_timer == 16'd0) begin
          w_state_next = S_IDLE;
        end
      end
`endif
      default: begin
        w_busy       = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign bus.grant    = w_grant;
  assign bus.done     = w_done;
  assign bus.busy     = w_busy;
  assign bus.cup_drop = w_cup_drop;
  assign bus.valve    = w_valve;
  assign bus.rinse    = w_rinse;

endmodule

// File: tb/tb_brew_arbiter.sv
// Directed bench for brew_arbiter: grant/done events go through an expectation queue,
// actuator phase lengths are counted per drink.
module tb_brew_arbiter;
  localparam int N     = 2;
  localparam int CUP   = 16;
  localparam int POUR  = 200;
  localparam int DRIP  = 32;
  localparam int DRINK = CUP + POUR + DRIP;

  typedef struct {
    bit           is_done;
    logic [N-1:0] bits;
    int           cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  ev_t  exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  brew_if #(.NUM_REQ(N)) bus ();

  brew_arbiter #(
    .NUM_REQ (N),
    .CUP_CYC (CUP),
    .POUR_CYC(POUR),
    .DRIP_CYC(DRIP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input bit is_done, input logic [N-1:0] bits, input int c);
    ev_t e;
    e.is_done = is_done;
    e.bits    = bits;
    e.cyc     = c;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input bit is_done, input logic [N-1:0] bits);
    ev_t e;
    n_tests++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL sb_unexpected observed=%s %0b at cyc %0d expected=no event",
             is_done ? "done" : "grant", bits, cyc);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_kind", 32'(is_done), 32'(e.is_done));
      check("sb_bits", 32'(bits), 32'(e.bits));
      check("sb_cycle", 32'(cyc), 32'(e.cyc));
    end
  endtask

  // Event monitor plus per-cycle exclusivity rules.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.grant != '0) sb_pop(1'b0, bus.grant);
      if (bus.done != '0) sb_pop(1'b1, bus.done);
      check("onehot_grant", 32'($onehot0(bus.grant)), 32'd1);
      check("onehot_done", 32'($onehot0(bus.done)), 32'd1);
      check("cup_valve_excl", 32'(bus.cup_drop && (bus.valve != 4'd0)), 32'd0);
    end
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Called on the grant cycle; walks the whole drink and counts each phase.
  task automatic phases(input logic [3:0] vexp, input int chg_k, input logic [3:0] chg_v,
                        output int nc, output int nv, output int nd);
    nc = 0;
    nv = 0;
    nd = 0;
    for (int k = 1; k <= DRINK; k++) begin
      @(negedge clk);
      if (k == chg_k) bus.sel[3:0] = chg_v;
      if (k == 1) check("cup_first", 32'(bus.cup_drop), 32'd1);
      if (bus.cup_drop) nc++;
      if (!bus.cup_drop && bus.valve == vexp) nv++;
      if (bus.busy && !bus.cup_drop && bus.valve == 4'd0) nd++;
    end
  endtask

  initial begin
    int d;
    int nc, nv, nd;
    int cnt_b, cnt_g;

    rst     = 1'b1;
    bus.req = '0;
    bus.sel = '0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cup", 32'(bus.cup_drop), 32'd0);
    check("rst_valve", 32'(bus.valve), 32'd0);
    check("rst_rinse", 32'(bus.rinse), 32'd0);
    rst = 1'b0;

    // Single request, select 3.
    @(negedge clk);
    bus.sel[3:0] = 4'h3;
    bus.req      = 2'b01;
    d = cyc + 1;
    push(1'b0, 2'b01, d);
    push(1'b1, 2'b01, d + DRINK + 1);
    wait_until(d);
    bus.req = 2'b00;
    phases(4'h3, 0, 4'h0, nc, nv, nd);
    check("t1_cup_len", 32'(nc), CUP);
    check("t1_pour_len", 32'(nv), POUR);
    check("t1_drip_len", 32'(nd), DRIP);
    @(negedge clk);
    @(negedge clk);
    check("t1_idle_busy", 32'(bus.busy), 32'd0);

    // Simultaneous pair from a fresh reset: 0 first, then 1, then 0 again.
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    bus.sel = 8'h65;
    bus.req = 2'b11;
    d = cyc + 1;
    push(1'b0, 2'b01, d);
    push(1'b1, 2'b01, d + DRINK + 1);
    push(1'b0, 2'b10, d + DRINK + 3);
    push(1'b1, 2'b10, d + 2*DRINK + 4);
    wait_until(d);
    bus.req = 2'b10;
    phases(4'h5, 0, 4'h0, nc, nv, nd);
    check("t2_pour0_len", 32'(nv), POUR);
    wait_until(d + DRINK + 3);
    bus.req = 2'b00;
    phases(4'h6, 0, 4'h0, nc, nv, nd);
    check("t2_pour1_len", 32'(nv), POUR);
    check("t2_cup1_len", 32'(nc), CUP);
    wait_until(d + 2*DRINK + 5);
    bus.req = 2'b11;
    d = cyc + 1;
    push(1'b0, 2'b01, d);
    wait_until(d);
    bus.req = 2'b10;

    // Reset on the 100th pour cycle: everything drops, no done follows.
    wait_until(d + CUP + 100);
    check("t5_pouring", 32'(bus.valve), 32'h5);
    rst     = 1'b1;
    bus.req = 2'b00;
    @(negedge clk);
    check("t5_valve_off", 32'(bus.valve), 32'd0);
    check("t5_busy_off", 32'(bus.busy), 32'd0);
    check("t5_cup_off", 32'(bus.cup_drop), 32'd0);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("t5_still_idle", 32'(bus.busy), 32'd0);

    // Zero select stays pending, then is served once a drink is chosen.
    bus.sel = 8'h00;
    bus.req = 2'b01;
    cnt_b = 0;
    cnt_g = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.busy) cnt_b++;
      if (bus.grant != '0) cnt_g++;
    end
    check("t3_zero_busy", 32'(cnt_b), 32'd0);
    check("t3_zero_grant", 32'(cnt_g), 32'd0);
    bus.sel[3:0] = 4'h1;
    d = cyc + 1;
    push(1'b0, 2'b01, d);
    push(1'b1, 2'b01, d + DRINK + 1);
    wait_until(d);
    bus.req = 2'b00;
    wait_until(d + DRINK + 2);

    // Select changes during CUP must not reach the valves.
    bus.sel[3:0] = 4'h2;
    bus.req      = 2'b01;
    d = cyc + 1;
    push(1'b0, 2'b01, d);
    push(1'b1, 2'b01, d + DRINK + 1);
    wait_until(d);
    bus.req = 2'b00;
    phases(4'h2, 5, 4'h8, nc, nv, nd);
    check("t4_frozen_sel", 32'(nv), POUR);
    check("t4_cup_len", 32'(nc), CUP);
    check("t4_drip_len", 32'(nd), DRIP);

    for (int t = 0; t < 600 && exp_q.size() > 0; t++) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
